serial_frame_receiver: RTL

- Receives framed serial words and presents each one as a parallel word through a one-entry output buffer with a valid/ready handshake.
- Counterpart to the team's LSB-first parallel-in/serial-out shift registers, which serialize the same frames on the transmit side.
- Sits between a serial line, sampled once per `bit_en` strobe, and a parallel consumer.
- Reports parity errors, framing errors and overrun.

---
 rtl/serial_frame_receiver.sv | 90 +++++++++
 1 files changed

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start(1), WIDTH data bits LSB first, optional even parity, stop(0).
// Received words land in a one-entry valid/ready output buffer.
module serial_frame_receiver #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             perr;
  logic             deliver;
  logic             xfer;

  assign deliver = bit_en && (state == STOP) && !serial_in;
  assign xfer    = out_valid && out_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      perr      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (bit_en) begin
        unique case (state)
          IDLE: if (serial_in) begin
            state <= DATA;
            cnt   <= '0;
          end
          DATA: begin
            shreg <= {serial_in, shreg[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) state <= PARITY_EN ? PARITY : STOP;
          end
          PARITY: begin
            perr  <= (^shreg) ^ serial_in;
            state <= STOP;
          end
          STOP: begin
            // A bad stop bit is consumed here; it never doubles as the next start bit.
            frame_err <= serial_in;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

  // A transfer on the delivery edge frees the slot, so the new word is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!out_valid || xfer) begin
          out_data   <= shreg;
          parity_err <= PARITY_EN && perr;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
